// File: rtl/imem_loader.sv
// imem_loader: instruction memory responder for the single-cycle core's fetch port.
//
// Packs a little-endian byte stream into 32-bit words, then serves combinational
// word-addressed fetches once the image is complete. While loading, last_pc is held
// at all-ones so the attached core stays parked at its reset PC.
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   ld_valid       load byte present
//   ld_byte        load byte
//   ld_last        ld_byte is the final byte of the image
//   ld_ready       a load byte is accepted this cycle (IDLE/LOAD only)
//   instr_addr     fetch word address
//   instr_data     fetched instruction, combinational from instr_addr
//   last_pc        index of the final loaded word; all-ones while not running
//   run            image complete, fetches live
//   err_overflow   sticky: bytes arrived beyond memory capacity
module imem_loader #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_data,
  output logic [31:0] last_pc,
  output logic        run,
  output logic        err_overflow
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  // One extra bit so the word counter can hold the saturated "memory full" value.
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [CntW-1:0]   word_cnt_q, word_cnt_d;
  logic [23:0]       lane_q, lane_d;
  logic [31:0]       last_pc_q, last_pc_d;
  logic              err_q, err_d;

  logic [31:0]       mem [Depth];

  logic              accept;
  logic              full;
  logic              wr_en;
  logic [31:0]       wr_word;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic              hit;

  // Current byte merged into the lanes gathered so far; lanes above it stay zero,
  // which gives the zero-filled partial word for free when ld_last cuts a word short.
  always_comb begin
    wr_word = '0;
    unique case (byte_cnt_q)
      2'd0:    wr_word = {24'h0, ld_byte};
      2'd1:    wr_word = {16'h0, ld_byte, lane_q[7:0]};
      2'd2:    wr_word = {8'h0, ld_byte, lane_q[15:0]};
      default: wr_word = {ld_byte, lane_q};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    lane_d     = lane_q;
    last_pc_d  = last_pc_q;
    err_d      = err_q;
    wr_en      = 1'b0;

    accept = ld_valid && (state_q != StRun);
    full   = (word_cnt_q == CntFull);
    wr_idx = word_cnt_q[DEPTH_LOG2-1:0];

    if (accept) begin
      if (full) begin
        // Memory is full: drop the byte but keep consuming until ld_last.
        err_d = 1'b1;
      end else if ((byte_cnt_q == 2'd3) || ld_last) begin
        wr_en      = 1'b1;
        word_cnt_d = word_cnt_q + CntW'(1);
        byte_cnt_d = 2'd0;
        lane_d     = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        lane_d     = wr_word[23:0];
      end

      if (ld_last) begin
        state_d   = StRun;
        // word_cnt_d is at least 1 here: the final byte either wrote a word or
        // arrived with the memory already full.
        last_pc_d = {{(32 - CntW){1'b0}}, word_cnt_d} - 32'd1;
      end else if (state_q == StIdle) begin
        state_d = StLoad;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= '0;
      lane_q     <= '0;
      last_pc_q  <= 32'hFFFF_FFFF;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      lane_q     <= lane_d;
      last_pc_q  <= last_pc_d;
      err_q      <= err_d;
    end
  end

  // Storage is not reset; reads are gated by word_cnt so stale contents never leak.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_word;
    end
  end

  assign run          = (state_q == StRun);
  assign ld_ready     = (state_q != StRun);
  assign last_pc      = last_pc_q;
  assign err_overflow = err_q;

  // Full 32-bit compare so addresses with upper bits set fall through to the NOP.
  assign hit        = run && (instr_addr < {{(32 - CntW){1'b0}}, word_cnt_q});
  assign instr_data = hit ? mem[instr_addr[DEPTH_LOG2-1:0]] : NOP_WORD;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam int CapBig   = 256;
  localparam int CapSmall = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = 8'h00;
  logic        ld_last = 1'b0;
  logic [31:0] instr_addr = 32'h0;

  logic        b_ready, b_run, b_err;
  logic [31:0] b_data, b_last_pc;
  logic        s_ready, s_run, s_err;
  logic [31:0] s_data, s_last_pc;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_LOG2(8), .NOP_WORD(Nop)) u_big (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_valid     (ld_valid),
    .ld_byte      (ld_byte),
    .ld_last      (ld_last),
    .ld_ready     (b_ready),
    .instr_addr   (instr_addr),
    .instr_data   (b_data),
    .last_pc      (b_last_pc),
    .run          (b_run),
    .err_overflow (b_err)
  );

  imem_loader #(.DEPTH_LOG2(2), .NOP_WORD(Nop)) u_small (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_valid     (ld_valid),
    .ld_byte      (ld_byte),
    .ld_last      (ld_last),
    .ld_ready     (s_ready),
    .instr_addr   (instr_addr),
    .instr_data   (s_data),
    .last_pc      (s_last_pc),
    .run          (s_run),
    .err_overflow (s_err)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference: list of bytes accepted for the current image, plus whether it is complete.
  logic [7:0] img[$];
  bit         m_run = 1'b0;

  function automatic int m_stored(int cap);
    return (img.size() < 4 * cap) ? img.size() : 4 * cap;
  endfunction

  function automatic logic [31:0] m_words(int cap);
    return 32'((m_stored(cap) + 3) / 4);
  endfunction

  function automatic logic [31:0] m_word(int cap, logic [31:0] i);
    logic [31:0] w = 32'h0;
    int st = m_stored(cap);
    for (int k = 0; k < 4; k++) begin
      int idx = 4 * int'(i) + k;
      if (idx < st) w[8*k +: 8] = img[idx];
    end
    return w;
  endfunction

  function automatic logic [31:0] m_data(int cap, logic [31:0] addr);
    if (m_run && (addr < m_words(cap))) return m_word(cap, addr);
    return Nop;
  endfunction

  function automatic logic [31:0] m_last_pc(int cap);
    return m_run ? (m_words(cap) - 32'd1) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic m_err(int cap);
    return img.size() > 4 * cap;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("big.ld_ready", {31'h0, b_ready}, {31'h0, !m_run});
      chk("big.run", {31'h0, b_run}, {31'h0, m_run});
      chk("big.err_overflow", {31'h0, b_err}, {31'h0, m_err(CapBig)});
      chk("big.last_pc", b_last_pc, m_last_pc(CapBig));
      chk("big.instr_data", b_data, m_data(CapBig, instr_addr));
      chk("small.ld_ready", {31'h0, s_ready}, {31'h0, !m_run});
      chk("small.run", {31'h0, s_run}, {31'h0, m_run});
      chk("small.err_overflow", {31'h0, s_err}, {31'h0, m_err(CapSmall)});
      chk("small.last_pc", s_last_pc, m_last_pc(CapSmall));
      chk("small.instr_data", s_data, m_data(CapSmall, instr_addr));
    end
  end

  // Called just after a rising edge; drives inputs, waits for the next edge, updates model.
  task automatic step(input bit v, input logic [7:0] b, input bit l);
    ld_valid = v;
    ld_byte  = b;
    ld_last  = l;
    @(posedge clk);
    if (rst_n && v && !m_run) begin
      img.push_back(b);
      if (l) m_run = 1'b1;
    end
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_reset();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    rst_n    = 1'b0;
    img.delete();
    m_run    = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic probe(input logic [31:0] a);
    instr_addr = a;
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 7);
    if (r < 5) return 32'($urandom_range(0, 12));
    if (r == 5) return 32'($urandom_range(250, 260));
    return $urandom;
  endfunction

  initial begin
    logic [7:0] prog[8];
    logic [7:0] part[5];
    logic [7:0] tiny[4];
    prog = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    part = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    tiny = '{8'h11, 8'h22, 8'h33, 8'h44};

    #1;
    rst_n  = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Before any load: core parked, fetches return NOP.
    probe(32'd0);
    chk("idle.instr_data", b_data, 32'h0000_0013);
    chk("idle.last_pc", b_last_pc, 32'hFFFF_FFFF);
    chk("idle.ld_ready", {31'h0, b_ready}, 32'd1);

    // Two-word program with an idle cycle in the middle of the stream.
    for (int i = 0; i < 8; i++) begin
      if (i == 3) step(1'b0, 8'hFF, 1'b1);
      step(1'b1, prog[i], i == 7);
    end
    probe(32'd0);
    chk("prog.word0", b_data, 32'h0010_0513);
    probe(32'd1);
    chk("prog.word1", b_data, 32'h0020_0593);
    chk("prog.small.word1", s_data, 32'h0020_0593);
    chk("prog.last_pc", b_last_pc, 32'd1);
    probe(32'd2);
    chk("prog.word2_nop", b_data, 32'h0000_0013);

    // Bytes offered while running are ignored.
    step(1'b1, 8'h77, 1'b1);
    step(1'b1, 8'h66, 1'b1);
    probe(32'd1);
    chk("run.ld_ready", {31'h0, b_ready}, 32'd0);
    chk("run.last_pc", b_last_pc, 32'd1);
    chk("run.word1", b_data, 32'h0020_0593);

    // Partial final word is zero-filled.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, part[i], i == 4);
    probe(32'd1);
    chk("part.word1", b_data, 32'h0000_00EE);
    probe(32'd0);
    chk("part.word0", b_data, 32'hDDCC_BBAA);
    chk("part.last_pc", b_last_pc, 32'd1);
    chk("part.err", {31'h0, b_err}, 32'd0);

    // 20 bytes: overflows the 4-word instance, fits the 256-word one.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i + 1), i == 19);
    probe(32'd3);
    chk("ovf.small.err", {31'h0, s_err}, 32'd1);
    chk("ovf.small.last_pc", s_last_pc, 32'd3);
    chk("ovf.small.word3", s_data, 32'h100F_0E0D);
    chk("ovf.big.last_pc", b_last_pc, 32'd4);
    probe(32'd4);
    chk("ovf.small.word4_nop", s_data, 32'h0000_0013);
    chk("ovf.big.word4", b_data, 32'h1413_1211);
    chk("ovf.big.err", {31'h0, b_err}, 32'd0);

    // Reset mid-load discards the partial image.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 8'hE0 + 8'(i), 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, tiny[i], i == 3);
    probe(32'd0);
    chk("rst.word0", b_data, 32'h4433_2211);
    chk("rst.last_pc", b_last_pc, 32'd0);
    probe(32'd1);
    chk("rst.word1_nop", b_data, 32'h0000_0013);

    // Randomized images with gaps, stray ld_last, aborts and post-run traffic.
    for (int img_n = 0; img_n < 30; img_n++) begin
      int len = $urandom_range(1, 40);
      do_reset();
      for (int k = 0; k < len; k++) begin
        while ($urandom_range(0, 3) == 0) begin
          instr_addr = rand_addr();
          step(1'b0, 8'($urandom), 1'($urandom));
        end
        if ($urandom_range(0, 39) == 0) break;
        instr_addr = rand_addr();
        step(1'b1, 8'($urandom), k == len - 1);
      end
      for (int c = 0; c < 8; c++) begin
        instr_addr = rand_addr();
        step(1'($urandom), 8'($urandom), 1'($urandom));
      end
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
